baccarat_deal_fsm: RTL and testbench
====================================

BACCARAT_DEAL_FSM -- requirements
Module: baccarat_deal_fsm

Interface
REQ-001 Parameters: none; all rules are fixed Punto Banco.
REQ-002 slow_clock  in  1  sole clock; all state changes on its rising edge.
REQ-003 resetb  in  1  reset, asynchronous, active-low.
REQ-004 step  in  1  advance request; one deal/decision action per cycle in which step=1.
REQ-005 pscore  in  4  player hand value 0-9, from the external score block, valid the cycle after any player load.
REQ-006 dscore  in  4  dealer hand value 0-9, same timing as pscore.
REQ-007 pcard3  in  4  player third-card rank (1-13, as held in the card register), valid the cycle after load_pcard3.
REQ-008 load_pcard1, load_pcard2, load_pcard3  out  1 each  one-cycle load strobes to player card registers.
REQ-009 load_dcard1, load_dcard2, load_dcard3  out  1 each  one-cycle load strobes to dealer card registers.
REQ-010 player_win_light, dealer_win_light  out  1 each  result; both high = tie.
REQ-011 round_done  out  1  high while in S_RESULT.

Function
REQ-012 States: S_P1, S_D1, S_P2, S_D2, S_DEC1, S_DEC2, S_RESULT; encoding free.
REQ-013 Each load strobe is combinational: (state matches) AND step; the state advances on the same edge, so each strobe lasts exactly one cycle per step.
REQ-014 With step=0 the FSM holds state and all strobes are 0.
REQ-015 Deal order on successive steps: S_P1 -> load_pcard1 -> S_D1 -> load_dcard1 -> S_P2 -> load_pcard2 -> S_D2 -> load_dcard2 -> S_DEC1.
REQ-016 S_DEC1 with step: if pscore>=8 or dscore>=8 (natural) -> S_RESULT, no strobe.
REQ-017 Else if pscore<=5: assert load_pcard3, go to S_DEC2.
REQ-018 Else (pscore 6-7): if dscore<=5, assert load_dcard3; go to S_RESULT either way.
REQ-019 pcard3 value v = pcard3 for ranks 1-9; v = 0 for ranks 10-13 and for 0/14/15.
REQ-020 S_DEC2 with step: dealer draws (load_dcard3) when dscore 0-2; dscore 3 and v!=8; dscore 4 and v in 2-7; dscore 5 and v in 4-7; dscore 6 and v in 6-7; never at dscore 7. Go to S_RESULT either way.
REQ-021 Win lights are registered; on every edge while in S_RESULT: player_win_light = (pscore>=dscore), dealer_win_light = (dscore>=pscore); outside S_RESULT both are 0 (registered).
REQ-022 Lights therefore assert one cycle after entering S_RESULT, after any D3 score has settled.
REQ-023 In S_RESULT, step has no effect unless REQ-029 applies; state holds indefinitely.
REQ-024 Score inputs are sampled only in S_DEC1, S_DEC2, S_RESULT; values outside 0-9 are don't-care.

Reset
REQ-025 resetb low forces, immediately and regardless of clock: state S_P1, both lights 0, round_done 0.
REQ-026 All strobes are 0 while resetb is low, even if step=1.
REQ-027 Reset mid-round abandons the round; the first step after release yields load_pcard1.

Configuration
REQ-028 Macro AUTO_REDEAL_EN selects redeal behaviour.
REQ-029 Defined: in S_RESULT, step moves to S_P1 and clears both lights on that edge; new round proceeds per REQ-015 without reset.
REQ-030 Undefined: S_RESULT is terminal; only resetb starts a new round.

Verification
REQ-031 Natural: after 4 deal steps pscore=9, dscore=3; step -> no load_pcard3/load_dcard3, S_RESULT, next cycle player_win_light=1, dealer_win_light=0.
REQ-032 pscore=4, dscore=3; step -> load_pcard3; pcard3=8; step -> no load_dcard3; final pscore=2, dscore=3 -> dealer_win_light=1 only.
REQ-033 pscore=6, dscore=5; step -> load_dcard3 only, direct to S_RESULT; dscore becomes 6 -> both lights high (tie).
REQ-034 pscore=2, dscore=6; load_pcard3 with pcard3=12 (v=0) -> dealer stands; pcard3=7 in a repeat -> load_dcard3 asserted.
REQ-035 Hold step=0 for 10 cycles in S_D1 -> no strobes, state unchanged; resetb low in S_P2 -> state S_P1 asynchronously, first post-reset step -> load_pcard1.
REQ-036 In S_RESULT, step: AUTO_REDEAL_EN defined -> lights 0 and next step gives load_pcard1; undefined -> lights and state unchanged.

Source files
------------

// File: rtl/baccarat_deal_fsm_if.sv
// Deal FSM handshake bundle: step request in, card load strobes and results out.
// Master drives step and score/card inputs; slave is the FSM.
interface baccarat_deal_fsm_if;
    logic       step;
    logic [3:0] pscore;
    logic [3:0] dscore;
    logic [3:0] pcard3;
    logic       load_pcard1;
    logic       load_pcard2;
    logic       load_pcard3;
    logic       load_dcard1;
    logic       load_dcard2;
    logic       load_dcard3;
    logic       player_win_light;
    logic       dealer_win_light;
    logic       round_done;

    modport master (
        output step, pscore, dscore, pcard3,
        input  load_pcard1, load_pcard2, load_pcard3,
        input  load_dcard1, load_dcard2, load_dcard3,
        input  player_win_light, dealer_win_light, round_done
    );

    modport slave (
        input  step, pscore, dscore, pcard3,
        output load_pcard1, load_pcard2, load_pcard3,
        output load_dcard1, load_dcard2, load_dcard3,
        output player_win_light, dealer_win_light, round_done
    );
endinterface

// File: rtl/baccarat_deal_fsm.sv
// Punto Banco deal/decision FSM with combinational load strobes.
// AUTO_REDEAL_EN: when defined, a step in S_RESULT starts a new round.
module baccarat_deal_fsm (
    input  logic               slow_clock,
    input  logic               resetb,
    baccarat_deal_fsm_if.slave bus
);
    typedef enum logic [2:0] {
        S_P1, S_D1, S_P2, S_D2, S_DEC1, S_DEC2, S_RESULT
    } state_t;

    state_t     state;
    logic       p_win;
    logic       d_win;
    logic       go;
    logic [3:0] v;
    logic       natural;
    logic       p_draw;
    logic       d_draw_dec1;
    logic       d_draw_dec2;

    // Strobes are gated by reset so none leak while resetb is low
    assign go = bus.step & resetb;

    assign v = (bus.pcard3 >= 4'd1 && bus.pcard3 <= 4'd9) ? bus.pcard3 : 4'd0;

    assign natural     = (bus.pscore >= 4'd8) || (bus.dscore >= 4'd8);
    assign p_draw      = !natural && (bus.pscore <= 4'd5);
    assign d_draw_dec1 = !natural && !p_draw && (bus.dscore <= 4'd5);

    always_comb begin
        d_draw_dec2 = 1'b0;
        unique case (1'b1)
            bus.dscore <= 4'd2: d_draw_dec2 = 1'b1;
            bus.dscore == 4'd3: d_draw_dec2 = (v != 4'd8);
            bus.dscore == 4'd4: d_draw_dec2 = (v >= 4'd2) && (v <= 4'd7);
            bus.dscore == 4'd5: d_draw_dec2 = (v >= 4'd4) && (v <= 4'd7);
            bus.dscore == 4'd6: d_draw_dec2 = (v >= 4'd6) && (v <= 4'd7);
            default:            d_draw_dec2 = 1'b0;
        endcase
    end

    assign bus.load_pcard1 = go && (state == S_P1);
    assign bus.load_dcard1 = go && (state == S_D1);
    assign bus.load_pcard2 = go && (state == S_P2);
    assign bus.load_dcard2 = go && (state == S_D2);
    assign bus.load_pcard3 = go && (state == S_DEC1) && p_draw;
    assign bus.load_dcard3 = go &&
        (((state == S_DEC1) && d_draw_dec1) ||
         ((state == S_DEC2) && d_draw_dec2));

    assign bus.player_win_light = p_win;
    assign bus.dealer_win_light = d_win;
    assign bus.round_done       = (state == S_RESULT);

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            state <= S_P1;
            p_win <= 1'b0;
            d_win <= 1'b0;
        end else begin
            // Re-evaluated every cycle so a late D3 score is picked up
            p_win <= 1'b0;
            d_win <= 1'b0;
            if (state == S_RESULT) begin
                p_win <= (bus.pscore >= bus.dscore);
                d_win <= (bus.dscore >= bus.pscore);
            end
            if (bus.step) begin
                case (state)
                    S_P1:     state <= S_D1;
                    S_D1:     state <= S_P2;
                    S_P2:     state <= S_D2;
                    S_D2:     state <= S_DEC1;
                    S_DEC1:   state <= p_draw ? S_DEC2 : S_RESULT;
                    S_DEC2:   state <= S_RESULT;
`ifdef AUTO_REDEAL_EN
                    S_RESULT: begin
                        state <= S_P1;
                        p_win <= 1'b0;
                        d_win <= 1'b0;
                    end
`else
                    S_RESULT: state <= S_RESULT;
`endif
                    default:  state <= S_P1;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_baccarat_deal_fsm.sv
// Directed-vector bench for baccarat_deal_fsm.
// Strobe vector order: {p1, d1, p2, d2, p3, d3}.
module tb_baccarat_deal_fsm;
    logic clk;
    logic resetb;
    int   n_tests;
    int   n_fail;

    baccarat_deal_fsm_if bus ();

    baccarat_deal_fsm dut (
        .slow_clock (clk),
        .resetb     (resetb),
        .bus        (bus)
    );

    localparam logic [5:0] NONE = 6'b000000;
    localparam logic [5:0] P1   = 6'b100000;
    localparam logic [5:0] D1   = 6'b010000;
    localparam logic [5:0] P2   = 6'b001000;
    localparam logic [5:0] D2   = 6'b000100;
    localparam logic [5:0] P3   = 6'b000010;
    localparam logic [5:0] D3   = 6'b000001;

    logic [5:0] stb;
    logic [1:0] lights;

    assign stb = {bus.load_pcard1, bus.load_dcard1, bus.load_pcard2,
                  bus.load_dcard2, bus.load_pcard3, bus.load_dcard3};
    assign lights = {bus.player_win_light, bus.dealer_win_light};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_step(input string tag, input logic [5:0] exp);
        @(negedge clk);
        bus.step = 1'b1;
        #1;
        check(tag, {2'b0, stb}, {2'b0, exp});
        @(posedge clk);
        #1;
        bus.step = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.step = 1'b0;
        resetb   = 1'b0;
        #2;
        resetb   = 1'b1;
    endtask

    task automatic deal4();
        do_step("deal_p1", P1);
        do_step("deal_d1", D1);
        do_step("deal_p2", P2);
        do_step("deal_d2", D2);
    endtask

    typedef struct {
        logic [3:0] d;
        logic [3:0] pc3;
        logic       draw;
    } dec2_vec_t;

    dec2_vec_t dec2_tab [10] = '{
        '{4'd6, 4'd12, 1'b0},
        '{4'd6, 4'd7,  1'b1},
        '{4'd3, 4'd8,  1'b0},
        '{4'd3, 4'd13, 1'b1},
        '{4'd4, 4'd1,  1'b0},
        '{4'd4, 4'd2,  1'b1},
        '{4'd5, 4'd4,  1'b1},
        '{4'd5, 4'd3,  1'b0},
        '{4'd7, 4'd6,  1'b0},
        '{4'd0, 4'd9,  1'b1}
    };

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        bus.step   = 1'b0;
        bus.pscore = 4'd0;
        bus.dscore = 4'd0;
        bus.pcard3 = 4'd0;
        resetb     = 1'b0;

        // Reset state, strobes suppressed even with step high
        #12;
        bus.step = 1'b1;
        #1;
        check("rst_strobes", {2'b0, stb}, 8'h00);
        check("rst_lights", {6'b0, lights}, 8'h00);
        check("rst_done", {7'b0, bus.round_done}, 8'h00);
        @(negedge clk);
        bus.step = 1'b0;
        resetb   = 1'b1;

        // Natural: player 9 vs dealer 3
        deal4();
        bus.pscore = 4'd9;
        bus.dscore = 4'd3;
        do_step("nat_step", NONE);
        check("nat_done", {7'b0, bus.round_done}, 8'h01);
        check("nat_lights_early", {6'b0, lights}, 8'h00);
        @(posedge clk);
        #1;
        check("nat_lights", {6'b0, lights}, 8'h02);

        // Step in S_RESULT
`ifdef AUTO_REDEAL_EN
        do_step("redeal_step", NONE);
        check("redeal_lights", {6'b0, lights}, 8'h00);
        check("redeal_done", {7'b0, bus.round_done}, 8'h00);
        do_step("redeal_p1", P1);
`else
        do_step("term_step", NONE);
        check("term_lights", {6'b0, lights}, 8'h02);
        check("term_done", {7'b0, bus.round_done}, 8'h01);
`endif

        // Player draws 8, dealer on 3 stands
        do_reset();
        deal4();
        bus.pscore = 4'd4;
        bus.dscore = 4'd3;
        do_step("p3_step", P3);
        check("p3_done", {7'b0, bus.round_done}, 8'h00);
        bus.pcard3 = 4'd8;
        bus.pscore = 4'd2;
        do_step("p3_dec2", NONE);
        check("p3_done2", {7'b0, bus.round_done}, 8'h01);
        @(posedge clk);
        #1;
        check("p3_lights", {6'b0, lights}, 8'h01);

        // Player stands on 6, dealer 5 draws to 6: tie
        do_reset();
        deal4();
        bus.pscore = 4'd6;
        bus.dscore = 4'd5;
        do_step("tie_step", D3);
        check("tie_done", {7'b0, bus.round_done}, 8'h01);
        bus.dscore = 4'd6;
        @(posedge clk);
        #1;
        check("tie_lights", {6'b0, lights}, 8'h03);

        // Both stand on 7 vs 6
        do_reset();
        deal4();
        bus.pscore = 4'd7;
        bus.dscore = 4'd6;
        do_step("stand_step", NONE);
        check("stand_done", {7'b0, bus.round_done}, 8'h01);

        // Dealer third-card table
        foreach (dec2_tab[i]) begin
            do_reset();
            deal4();
            bus.pscore = 4'd2;
            bus.dscore = dec2_tab[i].d;
            bus.pcard3 = 4'd0;
            do_step("dec2_p3", P3);
            bus.pcard3 = dec2_tab[i].pc3;
            do_step($sformatf("dec2_d%0d_c%0d", dec2_tab[i].d,
                              dec2_tab[i].pc3),
                    dec2_tab[i].draw ? D3 : NONE);
            check("dec2_done", {7'b0, bus.round_done}, 8'h01);
        end

        // Hold in S_D1 with no step
        do_reset();
        do_step("hold_p1", P1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("hold_idle", {2'b0, stb}, 8'h00);
        end
        do_step("hold_d1", D1);

        // Reset mid-round from S_P2
        @(negedge clk);
        resetb   = 1'b0;
        bus.step = 1'b1;
        #1;
        check("midrst_strobes", {2'b0, stb}, 8'h00);
        bus.step = 1'b0;
        resetb   = 1'b1;
        do_step("midrst_p1", P1);

        // Asynchronous reset from S_RESULT, away from any edge
        do_step("async_d1", D1);
        do_step("async_p2", P2);
        do_step("async_d2", D2);
        bus.pscore = 4'd8;
        bus.dscore = 4'd1;
        do_step("async_nat", NONE);
        @(posedge clk);
        #1;
        check("async_pre", {6'b0, lights}, 8'h02);
        @(negedge clk);
        #2;
        resetb = 1'b0;
        #1;
        check("async_lights", {6'b0, lights}, 8'h00);
        check("async_done", {7'b0, bus.round_done}, 8'h00);
        resetb = 1'b1;
        do_step("async_p1", P1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
